// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back staging queue and its forwarding matcher.
package wb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] index;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  // Register x0 is hard-wired, so a transfer aimed at it is never stored or forwarded.
  function automatic logic idx_is_live(input logic [REG_IDX_W-1:0] idx);
    return (idx != {REG_IDX_W{1'b0}});
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Bundle of producer handshakes, register-file write port and forwarding lookups.
// The queue sits on the slave side; producers/consumers drive the master side.
interface writeback_queue_if;
  import wb_pkg::*;

  logic                 a_valid;
  logic                 a_ready;
  logic [REG_IDX_W-1:0] a_index;
  logic [DATA_W-1:0]    a_data;

  logic                 m_valid;
  logic                 m_ready;
  logic [REG_IDX_W-1:0] m_index;
  logic [DATA_W-1:0]    m_data;

  logic                 wen;
  logic [REG_IDX_W-1:0] windex;
  logic [DATA_W-1:0]    wdata;

  logic [REG_IDX_W-1:0] index_1;
  logic [REG_IDX_W-1:0] index_2;
  logic                 fwd_hit_1;
  logic                 fwd_hit_2;
  logic [DATA_W-1:0]    fwd_data_1;
  logic [DATA_W-1:0]    fwd_data_2;

  modport slave (
    input  a_valid, a_index, a_data,
    input  m_valid, m_index, m_data,
    input  index_1, index_2,
    output a_ready, m_ready,
    output wen, windex, wdata,
    output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
  );

  modport master (
    output a_valid, a_index, a_data,
    output m_valid, m_index, m_data,
    output index_1, index_2,
    input  a_ready, m_ready,
    input  wen, windex, wdata,
    input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
  );

endinterface

// File: rtl/wb_fwd_match.sv
// Forwarding matcher: scans queue entries from oldest (head) to youngest and
// reports the youngest valid entry whose destination matches the lookup index.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                  i_entries [DEPTH],
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  logic [REG_IDX_W-1:0]       i_index,
  output logic                       o_hit,
  output logic [DATA_W-1:0]          o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  // Walk in age order so that a later (younger) match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] v_slot;
    o_hit  = 1'b0;
    o_data = {DATA_W{1'b0}};
    v_slot = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      v_slot = i_head + PTR_W'(k);
      if (idx_is_live(i_index) && i_valid[v_slot] &&
          (i_entries[v_slot].index == i_index)) begin
        o_hit  = 1'b1;
        o_data = i_entries[v_slot].data;
      end else begin
        o_hit  = o_hit;
        o_data = o_data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Write-back staging queue: merges ALU and MDU results into a circular FIFO,
// drains one entry per cycle into the register file and forwards pending data.
// Optional feature macro: WB_FWD_EN (forwarding matchers present when defined;
// otherwise fwd_hit_x/fwd_data_x are tied to zero).
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  writeback_queue_if.slave  wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_nonempty;
  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_need;
  logic             w_a_ready;
  logic             w_m_ready;
  logic             w_a_push;
  logic             w_m_push;
  logic [PTR_W-1:0] w_m_slot;

  logic              w_fwd_hit_1;
  logic              w_fwd_hit_2;
  logic [DATA_W-1:0] w_fwd_data_1;
  logic [DATA_W-1:0] w_fwd_data_2;

  // Credit accounting and push decisions; free space already counts the pop happening this cycle.
  always_comb begin
    w_nonempty = (r_count != {CNT_W{1'b0}});
    w_free     = DEPTH_C - r_count + CNT_W'(w_nonempty);
    if (wb.a_valid && idx_is_live(wb.a_index)) begin
      w_need = CNT_W'(2);
    end else begin
      w_need = CNT_W'(1);
    end
    w_a_ready = (w_free >= CNT_W'(1));
    w_m_ready = (w_free >= w_need);
    w_a_push  = wb.a_valid && w_a_ready && idx_is_live(wb.a_index);
    w_m_push  = wb.m_valid && w_m_ready && idx_is_live(wb.m_index);
    if (w_a_push) begin
      w_m_slot = r_tail + PTR_W'(1);
    end else begin
      w_m_slot = r_tail;
    end
  end

  // Queue state: ALU entry lands at tail (older), MDU entry right behind it; head pops when non-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {$bits(wb_entry_t){1'b0}};
      end
    end else begin
      if (w_a_push) begin
        r_mem[r_tail].index <= wb.a_index;
        r_mem[r_tail].data  <= wb.a_data;
      end
      if (w_m_push) begin
        r_mem[w_m_slot].index <= wb.m_index;
        r_mem[w_m_slot].data  <= wb.m_data;
      end
      r_tail  <= r_tail + PTR_W'(w_a_push) + PTR_W'(w_m_push);
      r_head  <= r_head + PTR_W'(w_nonempty);
      r_count <= r_count + CNT_W'(w_a_push) + CNT_W'(w_m_push) - CNT_W'(w_nonempty);
    end
  end

`ifdef WB_FWD_EN
  logic [DEPTH-1:0] w_valid;

  // An entry is pending when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] v_age;
    w_valid = {DEPTH{1'b0}};
    v_age   = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      v_age      = PTR_W'(i) - r_head;
      w_valid[i] = ({1'b0, v_age} < r_count);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_1 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_index   (wb.index_1),
    .o_hit     (w_fwd_hit_1),
    .o_data    (w_fwd_data_1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_2 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_index   (wb.index_2),
    .o_hit     (w_fwd_hit_2),
    .o_data    (w_fwd_data_2)
  );
`else
  logic w_unused_idx;

  // Without matchers the lookups never hit; consumers stall on pending destinations instead.
  always_comb begin
    w_fwd_hit_1  = 1'b0;
    w_fwd_hit_2  = 1'b0;
    w_fwd_data_1 = {DATA_W{1'b0}};
    w_fwd_data_2 = {DATA_W{1'b0}};
    w_unused_idx = ^{wb.index_1, wb.index_2};
  end
`endif

  // Drive the bus: head entry goes to the register-file port whenever the queue holds anything.
  always_comb begin
    wb.a_ready = w_a_ready;
    wb.m_ready = w_m_ready;
    if (w_nonempty) begin
      wb.wen    = 1'b1;
      wb.windex = r_mem[r_head].index;
      wb.wdata  = r_mem[r_head].data;
    end else begin
      wb.wen    = 1'b0;
      wb.windex = {REG_IDX_W{1'b0}};
      wb.wdata  = {DATA_W{1'b0}};
    end
    wb.fwd_hit_1  = w_fwd_hit_1;
    wb.fwd_hit_2  = w_fwd_hit_2;
    wb.fwd_data_1 = w_fwd_data_1;
    wb.fwd_data_2 = w_fwd_data_2;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4): reset state, single and dual
// pushes, index-0 transfers, back-pressure with wrap-around, and reset mid-drain.
// Forwarding expectations follow WB_FWD_EN.
module tb_writeback_queue;
  import wb_pkg::*;

`ifdef WB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vectors;
  int   n_miscompares;

  writeback_queue_if u_if ();

  writeback_queue #(.DEPTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .wb  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.a_valid = 1'b0;
    u_if.a_index = 5'd0;
    u_if.a_data  = 32'h0;
    u_if.m_valid = 1'b0;
    u_if.m_index = 5'd0;
    u_if.m_data  = 32'h0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wb_entry_t exp_q[$];
    wb_entry_t got_q[$];
    wb_entry_t ent;
    int        mcount;
    int        free;
    logic      exp_m;

    n_vectors     = 0;
    n_miscompares = 0;
    rst           = 1'b1;
    idle_inputs();
    u_if.index_1  = 5'd0;
    u_if.index_2  = 5'd0;

    // reset state, with a live ALU request still getting m_ready
    u_if.a_valid = 1'b1;
    u_if.a_index = 5'd4;
    #2;
    check_vec("rst_wen",      u_if.wen,       32'd0);
    check_vec("rst_windex",   u_if.windex,    32'd0);
    check_vec("rst_wdata",    u_if.wdata,     32'd0);
    check_vec("rst_fwd_hit1", u_if.fwd_hit_1, 32'd0);
    check_vec("rst_a_ready",  u_if.a_ready,   32'd1);
    check_vec("rst_m_ready",  u_if.m_ready,   32'd1);
    idle_inputs();
    #5;
    rst = 1'b0;
    next_cycle();

    // single ALU write
    u_if.a_valid = 1'b1;
    u_if.a_index = 5'd5;
    u_if.a_data  = 32'h1234;
    u_if.index_1 = 5'd5;
    @(negedge clk);
    check_vec("single_a_ready",  u_if.a_ready,   32'd1);
    check_vec("single_pre_wen",  u_if.wen,       32'd0);
    check_vec("single_pre_hit",  u_if.fwd_hit_1, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_vec("single_wen",    u_if.wen,        32'd1);
    check_vec("single_windex", u_if.windex,     32'd5);
    check_vec("single_wdata",  u_if.wdata,      32'h1234);
    check_vec("single_hit",    u_if.fwd_hit_1,  {31'd0, FWD_ON});
    check_vec("single_fdata",  u_if.fwd_data_1, FWD_ON ? 32'h1234 : 32'h0);
    next_cycle();
    @(negedge clk);
    check_vec("single_post_wen", u_if.wen, 32'd0);
    next_cycle();

    // dual push to the same destination: ALU older, MDU younger
    u_if.a_valid = 1'b1;
    u_if.a_index = 5'd3;
    u_if.a_data  = 32'hA;
    u_if.m_valid = 1'b1;
    u_if.m_index = 5'd3;
    u_if.m_data  = 32'hB;
    u_if.index_1 = 5'd3;
    u_if.index_2 = 5'd3;
    @(negedge clk);
    check_vec("dual_a_ready", u_if.a_ready, 32'd1);
    check_vec("dual_m_ready", u_if.m_ready, 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_vec("dual_wen0",    u_if.wen,        32'd1);
    check_vec("dual_windex0", u_if.windex,     32'd3);
    check_vec("dual_wdata0",  u_if.wdata,      32'hA);
    check_vec("dual_hit1_0",  u_if.fwd_hit_1,  {31'd0, FWD_ON});
    check_vec("dual_fdat1_0", u_if.fwd_data_1, FWD_ON ? 32'hB : 32'h0);
    check_vec("dual_fdat2_0", u_if.fwd_data_2, FWD_ON ? 32'hB : 32'h0);
    next_cycle();
    @(negedge clk);
    check_vec("dual_wen1",    u_if.wen,        32'd1);
    check_vec("dual_wdata1",  u_if.wdata,      32'hB);
    check_vec("dual_hit1_1",  u_if.fwd_hit_1,  {31'd0, FWD_ON});
    check_vec("dual_fdat1_1", u_if.fwd_data_1, FWD_ON ? 32'hB : 32'h0);
    next_cycle();
    @(negedge clk);
    check_vec("dual_wen2",   u_if.wen,       32'd0);
    check_vec("dual_hit1_2", u_if.fwd_hit_1, 32'd0);
    next_cycle();

    // index 0 transfer is accepted but dropped
    u_if.a_valid = 1'b1;
    u_if.a_index = 5'd0;
    u_if.a_data  = 32'hFFFF;
    u_if.index_1 = 5'd0;
    u_if.index_2 = 5'd0;
    @(negedge clk);
    check_vec("idx0_a_ready", u_if.a_ready,   32'd1);
    check_vec("idx0_hit1",    u_if.fwd_hit_1, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_vec("idx0_wen",  u_if.wen,       32'd0);
    check_vec("idx0_hit1b", u_if.fwd_hit_1, 32'd0);
    check_vec("idx0_hit2b", u_if.fwd_hit_2, 32'd0);
    next_cycle();

    // back-pressure: both producers every cycle, model tracks occupancy
    mcount = 0;
    for (int k = 0; k < 12; k++) begin
      u_if.a_valid = 1'b1;
      u_if.a_index = 5'(k + 1);
      u_if.a_data  = 32'h100 + 32'(k);
      u_if.m_valid = 1'b1;
      u_if.m_index = 5'(k + 17);
      u_if.m_data  = 32'h200 + 32'(k);
      @(negedge clk);
      free  = 4 - mcount + ((mcount != 0) ? 1 : 0);
      exp_m = (free >= 2);
      check_vec("bp_a_ready", u_if.a_ready, 32'd1);
      check_vec("bp_m_ready", u_if.m_ready, {31'd0, exp_m});
      if (u_if.wen) begin
        ent.index = u_if.windex;
        ent.data  = u_if.wdata;
        got_q.push_back(ent);
      end
      ent.index = u_if.a_index;
      ent.data  = u_if.a_data;
      exp_q.push_back(ent);
      if (exp_m) begin
        ent.index = u_if.m_index;
        ent.data  = u_if.m_data;
        exp_q.push_back(ent);
      end
      mcount = mcount + 1 + (exp_m ? 1 : 0) - ((mcount != 0) ? 1 : 0);
      next_cycle();
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (u_if.wen) begin
        ent.index = u_if.windex;
        ent.data  = u_if.wdata;
        got_q.push_back(ent);
      end
      next_cycle();
    end
    check_vec("bp_write_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check_vec($sformatf("bp_idx_%0d", i),  {27'd0, got_q[i].index}, {27'd0, exp_q[i].index});
        check_vec($sformatf("bp_data_%0d", i), got_q[i].data, exp_q[i].data);
      end else begin
        check_vec($sformatf("bp_missing_%0d", i), 32'hDEAD_DEAD, exp_q[i].data);
      end
    end

    // reset mid-drain: three entries pending when rst arrives between edges
    u_if.a_valid = 1'b1;
    u_if.a_index = 5'd7;
    u_if.a_data  = 32'h71;
    u_if.m_valid = 1'b1;
    u_if.m_index = 5'd8;
    u_if.m_data  = 32'h81;
    next_cycle();
    u_if.a_index = 5'd9;
    u_if.a_data  = 32'h91;
    u_if.m_index = 5'd10;
    u_if.m_data  = 32'hA1;
    @(negedge clk);
    check_vec("mid_m_ready", u_if.m_ready, 32'd1);
    check_vec("mid_windex",  u_if.windex,  32'd7);
    next_cycle();
    idle_inputs();
    u_if.index_1 = 5'd9;
    #1;
    check_vec("mid_pending_wen", u_if.wen,    32'd1);
    check_vec("mid_pending_idx", u_if.windex, 32'd8);
    #1;
    rst = 1'b1;
    #1;
    check_vec("mid_rst_wen",    u_if.wen,       32'd0);
    check_vec("mid_rst_windex", u_if.windex,    32'd0);
    check_vec("mid_rst_wdata",  u_if.wdata,     32'd0);
    check_vec("mid_rst_hit1",   u_if.fwd_hit_1, 32'd0);
    check_vec("mid_rst_a_rdy",  u_if.a_ready,   32'd1);
    check_vec("mid_rst_m_rdy",  u_if.m_ready,   32'd1);
    next_cycle();
    #2;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_vec($sformatf("post_rst_wen_%0d", k), u_if.wen, 32'd0);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
